// File: rtl/fpu_64_subtractor_pipe.sv
// fpu_64_subtractor_pipe
//   Pipelined IEEE-754 binary64 subtractor: result = a - b.
//   Stage 1 aligns operands, stage 2 adds/subtracts the 56-bit significands,
//   stage 3 normalises, rounds and applies special-case overrides.
//   The whole pipe advances as one unit when the output slot is free or
//   being drained. Denormal inputs are read as signed zero, and tiny results
//   are flushed to signed zero.
//
//   Optional build macro FPU64_SUB_ADD_MODE_EN adds an 'op' input. op=0
//   computes a - b and op=1 computes a + b. op travels with its operands.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   operand handshake (in_ready = !out_valid | out_ready)
//   a, b                binary64 minuend / subtrahend
//   op                  (FPU64_SUB_ADD_MODE_EN only) 0 = sub, 1 = add
//   out_valid/out_ready result handshake
//   result              binary64 difference
//   overflow            result saturated to signed infinity
//   underflow           nonzero result below min normal, flushed to signed zero
module fpu_64_subtractor_pipe #(
  parameter int          ROUND_MODE   = 0,
  parameter logic [63:0] QNAN_PATTERN = 64'h7FF8000000000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
`ifdef FPU64_SUB_ADD_MODE_EN
  input  logic        op,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        overflow,
  output logic        underflow
);

  localparam int STAGES = 3;

  logic [STAGES:0] vld_pipe;
  logic            advance;

  assign vld_pipe[0] = in_valid;
  assign out_valid   = vld_pipe[STAGES];
  assign advance     = ~vld_pipe[STAGES] | out_ready;
  assign in_ready    = advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       vld_pipe[STAGES:1] <= '0;
    else if (advance) vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  // ---------------------------------------------------------------- stage 1
  logic        sa, sb;
  logic        a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
  logic [52:0] ma, mb;
  logic        swap;
  logic        sx, sy;
  logic [10:0] ex, ey, diff;
  logic [52:0] mx, my;
  logic [55:0] y_full, y_lost, y_al;

  assign sa = a[63];
`ifdef FPU64_SUB_ADD_MODE_EN
  assign sb = b[63] ^ ~op;
`else
  assign sb = ~b[63];
`endif

  assign a_zero = (a[62:52] == 11'd0);
  assign b_zero = (b[62:52] == 11'd0);
  assign a_nan  = (&a[62:52]) & (|a[51:0]);
  assign b_nan  = (&b[62:52]) & (|b[51:0]);
  assign a_inf  = (&a[62:52]) & ~(|a[51:0]);
  assign b_inf  = (&b[62:52]) & ~(|b[51:0]);
  assign ma     = a_zero ? 53'd0 : {1'b1, a[51:0]};
  assign mb     = b_zero ? 53'd0 : {1'b1, b[51:0]};

  // Larger magnitude goes to x so the stage-2 subtract never goes negative.
  assign swap = {b[62:52], mb} > {a[62:52], ma};
  assign sx   = swap ? sb : sa;
  assign sy   = swap ? sa : sb;
  assign ex   = swap ? b[62:52] : a[62:52];
  assign ey   = swap ? a[62:52] : b[62:52];
  assign mx   = swap ? mb : ma;
  assign my   = swap ? ma : mb;
  assign diff = ex - ey;

  // Any bit shifted out below the sticky position is ORed (jammed) into bit 0.
  assign y_full = {my, 3'b000};
  always_comb begin
    y_lost = '0;
    y_al   = '0;
    if (diff >= 11'd56) begin
      y_al = {55'd0, |my};
    end else begin
      y_lost = y_full & ~({56{1'b1}} << diff[5:0]);
      y_al   = (y_full >> diff[5:0]) | {55'd0, |y_lost};
    end
  end

  logic        s1_sx, s1_sy, s1_nan, s1_inf, s1_inf_sign;
  logic [10:0] s1_exp;
  logic [55:0] s1_mx, s1_my;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sx <= 1'b0; s1_sy <= 1'b0; s1_nan <= 1'b0; s1_inf <= 1'b0;
      s1_inf_sign <= 1'b0; s1_exp <= '0; s1_mx <= '0; s1_my <= '0;
    end else if (advance) begin
      s1_sx       <= sx;
      s1_sy       <= sy;
      // inf - inf with equal signs shows up as opposite effective signs here
      s1_nan      <= a_nan | b_nan | (a_inf & b_inf & (sa ^ sb));
      s1_inf      <= a_inf | b_inf;
      s1_inf_sign <= a_inf ? sa : sb;
      s1_exp      <= ex;
      s1_mx       <= {mx, 3'b000};
      s1_my       <= y_al;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [56:0] sum;
  assign sum = (s1_sx ^ s1_sy) ? ({1'b0, s1_mx} - {1'b0, s1_my})
                               : ({1'b0, s1_mx} + {1'b0, s1_my});

  logic        s2_sign, s2_zsign, s2_nan, s2_inf, s2_inf_sign;
  logic [10:0] s2_exp;
  logic [56:0] s2_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sign <= 1'b0; s2_zsign <= 1'b0; s2_nan <= 1'b0; s2_inf <= 1'b0;
      s2_inf_sign <= 1'b0; s2_exp <= '0; s2_sum <= '0;
    end else if (advance) begin
      s2_sign     <= s1_sx;
      // Exact zero is -0 only when both effective operands are -0.
      s2_zsign    <= s1_sx & s1_sy;
      s2_nan      <= s1_nan;
      s2_inf      <= s1_inf;
      s2_inf_sign <= s1_inf_sign;
      s2_exp      <= s1_exp;
      s2_sum      <= sum;
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic [5:0]         lz;
  logic [55:0]        norm;
  logic signed [12:0] e_norm, e_fin;
  logic               rnd_inc, is_zero;
  logic [52:0]        frac_r;
  logic [63:0]        nxt_res;
  logic               nxt_of, nxt_uf;

  always_comb begin
    lz = '0;
    for (int i = 0; i < 56; i++)
      if (s2_sum[i]) lz = 6'(55 - i);
  end

  always_comb begin
    norm    = '0;
    e_norm  = '0;
    if (s2_sum[56]) begin
      // carry out of the add: shift right one, keep the dropped bit sticky
      norm   = {s2_sum[56:2], s2_sum[1] | s2_sum[0]};
      e_norm = $signed({2'b00, s2_exp}) + 13'sd1;
    end else begin
      norm   = s2_sum[55:0] << lz;
      e_norm = $signed({2'b00, s2_exp}) - $signed({7'd0, lz});
    end
    is_zero = ~norm[55];
    rnd_inc = (ROUND_MODE == 0) ? (norm[2] & (norm[1] | norm[0] | norm[3])) : 1'b0;
    frac_r  = {1'b0, norm[54:3]} + {52'd0, rnd_inc};
    // A carry out of the fraction leaves it all-zero and bumps the exponent.
    e_fin   = e_norm + $signed({12'd0, frac_r[52]});

    nxt_res = {s2_sign, e_fin[10:0], frac_r[51:0]};
    nxt_of  = 1'b0;
    nxt_uf  = 1'b0;
    if (s2_nan) begin
      nxt_res = QNAN_PATTERN;
    end else if (s2_inf) begin
      nxt_res = {s2_inf_sign, 11'h7FF, 52'd0};
    end else if (is_zero) begin
      nxt_res = {s2_zsign, 63'd0};
    end else if (e_fin >= 13'sd2047) begin
      nxt_res = {s2_sign, 11'h7FF, 52'd0};
      nxt_of  = 1'b1;
    end else if (e_fin < 13'sd1) begin
      nxt_res = {s2_sign, 63'd0};
      nxt_uf  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (advance) begin
      result    <= nxt_res;
      overflow  <= nxt_of;
      underflow <= nxt_uf;
    end
  end

endmodule

// File: tb/tb_fpu_64_subtractor_pipe.sv
// Self-checking bench for fpu_64_subtractor_pipe (default build: subtract only,
// round-to-nearest-even). Reference model uses host double arithmetic with
// input denormal flush and the block's overflow/underflow/NaN rules on top.
module tb_fpu_64_subtractor_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0, b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic        overflow, underflow;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fpu_64_subtractor_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .underflow(underflow)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {overflow, underflow, result}
  function automatic logic [65:0] model(input logic [63:0] x, input logic [63:0] y);
    logic [63:0] fx, fy, r;
    real d;
    fx = (x[62:52] == 11'd0) ? {x[63], 63'd0} : x;
    fy = (y[62:52] == 11'd0) ? {y[63], 63'd0} : y;
    d  = $bitstoreal(fx) - $bitstoreal(fy);
    r  = $realtobits(d);
    if ((&r[62:52]) && (|r[51:0])) return {2'b00, 64'h7FF8000000000000};
    if (&r[62:52]) return ((&fx[62:52]) || (&fy[62:52])) ? {2'b00, r} : {2'b10, r};
    if ((r[62:52] == 11'd0) && (|r[51:0])) return {2'b01, r[63], 63'd0};
    return {2'b00, r};
  endfunction

  function automatic logic [63:0] rnd_op(input logic [63:0] other);
    logic [63:0] v;
    logic [10:0] e;
    logic        s;
    int          k;
    v = {$urandom, $urandom};
    s = v[63];
    k = $urandom_range(0, 9);
    case (k)
      0: ;
      1: begin
        case ($urandom_range(0, 7))
          0: v = 64'h0;
          1: v = 64'h8000000000000000;
          2: v = 64'h7FF0000000000000;
          3: v = 64'hFFF0000000000000;
          4: v = 64'h7FF8000000000000;
          5: v = 64'h7FF0000000000001;
          6: v = {s, 11'd0, v[51:0]};
          default: v = {s, 11'h7FE, v[51:0]};
        endcase
      end
      2, 3: begin
        e = other[62:52] + 11'($urandom_range(0, 2)) - 11'd1;
        v = {s, e, v[51:0]};
      end
      4: v = other ^ {54'd0, v[9:0]};
      5: begin
        e = other[62:52] - 11'($urandom_range(0, 60));
        v = {s, e, v[51:0]};
      end
      6: v = {s, 11'($urandom_range(2040, 2046)), v[51:0]};
      7: v = {s, 11'($urandom_range(1, 3)), v[51:0]};
      default: v = {s, 11'($urandom_range(900, 1150)), v[51:0]};
    endcase
    return v;
  endfunction

  // Scoreboard: expected values queued at operand transfer, popped at result transfer.
  logic [65:0] sb_q[$];
  logic [65:0] mon_exp;
  int acc_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
          mon_exp = sb_q.pop_front();
          chk("sb_result", result, mon_exp[63:0]);
          chk("sb_flags", {62'd0, overflow, underflow}, {62'd0, mon_exp[65:64]});
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(model(a, b));
        acc_cnt++;
      end
    end
  end

  task automatic single(input string tag, input logic [63:0] ta, input logic [63:0] tb,
                        input logic [63:0] er, input logic eo, input logic eu);
    int n;
    @(posedge clk); #1;
    a = ta; b = tb; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (n < 20) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd3);
    chk({tag, "_res"}, result, er);
    chk({tag, "_of"}, 64'(overflow), 64'(eo));
    chk({tag, "_uf"}, 64'(underflow), 64'(eu));
  endtask

  task automatic drain();
    int n;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_bound", 64'(n < 100), 64'd1);
  endtask

  logic [63:0] held;
  int          acc0;

  initial begin
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_of", 64'(overflow), 64'd0);
    chk("rst_uf", 64'(underflow), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    #20 rst_n = 1'b1;

    single("t1_142m12", 64'h4061D00000000000, 64'h4029000000000000, 64'h4060400000000000, 1'b0, 1'b0);
    single("t2_one_one", 64'h3FF0000000000000, 64'h3FF0000000000000, 64'h0, 1'b0, 1'b0);
    single("t2_negzero", 64'h8000000000000000, 64'h0000000000000000, 64'h8000000000000000, 1'b0, 1'b0);
    single("t3_ovf", 64'h7FEFFFFFFFFFFFFF, 64'hFFEFFFFFFFFFFFFF, 64'h7FF0000000000000, 1'b1, 1'b0);
    single("t4_unf", 64'h0020000000000000, 64'h001FFFFFFFFFFFFF, 64'h0, 1'b0, 1'b1);
    single("t5_infinf", 64'h7FF0000000000000, 64'h7FF0000000000000, 64'h7FF8000000000000, 1'b0, 1'b0);
    single("t5_inffin", 64'h7FF0000000000000, 64'h4004000000000000, 64'h7FF0000000000000, 1'b0, 1'b0);
    drain();

    // Backpressure: exactly three operands fit, then the pipe stalls.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; acc0 = acc_cnt;
    repeat (8) begin
      a = rnd_op({$urandom, $urandom});
      b = rnd_op(a);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("bp_accepts", 64'(acc_cnt - acc0), 64'd3);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    held = result;
    repeat (4) begin
      @(negedge clk);
      chk("bp_hold", result, held);
    end
    drain();

    // Reset with a full pipe: output drops at once, nothing stale afterwards.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (5) begin
      a = rnd_op({$urandom, $urandom});
      b = rnd_op(a);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_result", result, 64'd0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_idle", 64'(out_valid), 64'd0);
    single("post_rst", 64'h4061D00000000000, 64'h4029000000000000, 64'h4060400000000000, 1'b0, 1'b0);
    drain();

    // Randomised traffic with random stalls and bubbles.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      a = rnd_op({$urandom, $urandom});
      b = rnd_op(a);
    end
    drain();
    chk("final_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
